// File: rtl/feedback_controller.sv
// Training-pass feedback controller: sums clause votes serially, clamps the sum,
// then walks the clauses issuing LFSR-gated Type I / Type II feedback pulses.
module feedback_controller #(
  parameter int N_CLAUSES = 8,
  parameter int THRESH    = 4,
  parameter int SW        = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        y,
  input  logic [N_CLAUSES-1:0]        clause_out,
  output logic                        busy,
  output logic signed [SW-1:0]        class_sum,
  output logic [N_CLAUSES-1:0]        pos_fb,
  output logic [N_CLAUSES-1:0]        neg_fb,
  output logic                        done
);

  localparam int IW = (N_CLAUSES > 1) ? $clog2(N_CLAUSES) : 1;
  localparam logic signed [SW-1:0] T_POS = SW'(THRESH);
  localparam logic signed [SW-1:0] T_NEG = -SW'(THRESH);
  localparam logic signed [SW-1:0] ONE   = SW'(1);

  typedef enum logic [1:0] {IDLE, SUM, FB, DONE} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic signed [SW-1:0]   acc, acc_nxt, class_sum_nxt, contrib, sum_now;
  logic [N_CLAUSES-1:0]   snap, snap_nxt, pos_nxt, neg_nxt;
  logic                   y_snap, y_snap_nxt;
  logic [15:0]            lfsr, lfsr_nxt;
  logic                   last_idx;
  logic                   fb_en;
  logic [IW-1:0]          fb_idx;
  logic [7:0]             fb_r;
  logic signed [SW-1:0]   fb_cs;

  function automatic logic signed [SW-1:0] clamp_sum(input logic signed [SW-1:0] s);
    if (s > T_POS)      return T_POS;
    else if (s < T_NEG) return T_NEG;
    else                return s;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // k = T -/+ class_sum lies in 0..2T; grant when r*2T < k*256.
  function automatic logic fb_grant(input logic [7:0] r, input logic signed [SW-1:0] cs,
                                    input logic yv);
    int k;
    k = yv ? (THRESH - int'(cs)) : (THRESH + int'(cs));
    return (int'(r) * 2 * THRESH) < (k * 256);
  endfunction

  assign last_idx = (idx == IW'(N_CLAUSES - 1));
  assign contrib  = snap[idx] ? (idx[0] ? -ONE : ONE) : '0;
  assign sum_now  = acc + contrib;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // The feedback registers are loaded with the decision for the FB cycle being
  // entered, using the LFSR value that will be current in that cycle.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    acc_nxt       = acc;
    class_sum_nxt = class_sum;
    snap_nxt      = snap;
    y_snap_nxt    = y_snap;
    lfsr_nxt      = lfsr;
    pos_nxt       = '0;
    neg_nxt       = '0;
    fb_en         = 1'b0;
    fb_idx        = '0;
    fb_r          = lfsr[7:0];
    fb_cs         = class_sum;
    case (state)
      IDLE: begin
        if (start) begin
          snap_nxt   = clause_out;
          y_snap_nxt = y;
          acc_nxt    = '0;
          idx_nxt    = '0;
          state_nxt  = SUM;
        end
      end
      SUM: begin
        acc_nxt = sum_now;
        idx_nxt = idx + IW'(1);
        if (last_idx) begin
          class_sum_nxt = clamp_sum(sum_now);
          idx_nxt       = '0;
          state_nxt     = FB;
          fb_en         = 1'b1;
          fb_idx        = '0;
          fb_r          = lfsr[7:0];
          fb_cs         = clamp_sum(sum_now);
        end
      end
      FB: begin
        lfsr_nxt = lfsr_step(lfsr);
        if (last_idx) begin
          idx_nxt   = '0;
          state_nxt = DONE;
        end else begin
          idx_nxt = idx + IW'(1);
          fb_en   = 1'b1;
          fb_idx  = idx + IW'(1);
          fb_r    = lfsr_nxt[7:0];
          fb_cs   = class_sum;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (fb_en && fb_grant(fb_r, fb_cs, y_snap)) begin
      if (y_snap ^ fb_idx[0]) pos_nxt[fb_idx] = 1'b1;
      else                    neg_nxt[fb_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      class_sum <= '0;
      snap      <= '0;
      y_snap    <= 1'b0;
      lfsr      <= 16'hACE1;
      pos_fb    <= '0;
      neg_fb    <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      acc       <= acc_nxt;
      class_sum <= class_sum_nxt;
      snap      <= snap_nxt;
      y_snap    <= y_snap_nxt;
      lfsr      <= lfsr_nxt;
      pos_fb    <= pos_nxt;
      neg_fb    <= neg_nxt;
    end
  end

endmodule

// File: tb/tb_feedback_controller.sv
// Scoreboard bench for feedback_controller: per-cycle expectations are queued
// from a reference model when a pass is launched and popped as cycles elapse.
module tb_feedback_controller;

  logic              clk, rst;
  logic              start, y;
  logic [7:0]        clause_out;
  logic              busy, done;
  logic signed [5:0] class_sum;
  logic [7:0]        pos_fb, neg_fb;

  logic              start2, y2;
  logic [7:0]        clause2;
  logic              busy2, done2;
  logic signed [5:0] class_sum2;
  logic [7:0]        pos_fb2, neg_fb2;

  typedef struct {
    logic       busy;
    logic       done;
    logic [5:0] cs;
    logic [7:0] pos;
    logic [7:0] neg;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [15:0] m_lfsr;
  int         prev_cs;
  logic [15:0] obs_fb[8];
  logic [15:0] seq_a[8];

  feedback_controller #(.N_CLAUSES(8), .THRESH(4), .SW(6)) u_dut (
    .clk(clk), .rst(rst), .start(start), .y(y), .clause_out(clause_out),
    .busy(busy), .class_sum(class_sum), .pos_fb(pos_fb), .neg_fb(neg_fb), .done(done)
  );

  feedback_controller #(.N_CLAUSES(8), .THRESH(2), .SW(6)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .y(y2), .clause_out(clause2),
    .busy(busy2), .class_sum(class_sum2), .pos_fb(pos_fb2), .neg_fb(neg_fb2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_step(input logic [15:0] l);
    logic fbit;
    fbit = ^(l & 16'hB400);
    return (l << 1) | {15'd0, fbit};
  endfunction

  // Launches one pass on the T=4 instance; must be called just after a negedge.
  task automatic run_pass(input logic [7:0] cl, input logic yv, input logic hold);
    int raw, cs, k, r;
    exp_t e;
    logic [7:0] p, n;
    raw = 0;
    for (int i = 0; i < 8; i++)
      if (cl[i]) raw += (i % 2 == 0) ? 1 : -1;
    cs = (raw > 4) ? 4 : (raw < -4) ? -4 : raw;
    k  = yv ? (4 - cs) : (4 + cs);
    for (int c = 1; c <= 8; c++) begin
      e = '{busy: 1'b1, done: 1'b0, cs: 6'(prev_cs), pos: 8'h00, neg: 8'h00};
      exp_q.push_back(e);
    end
    for (int j = 0; j < 8; j++) begin
      r = int'(m_lfsr[7:0]);
      p = 8'h00;
      n = 8'h00;
      if (r * 8 < k * 256) begin
        if ((yv == 1'b1) == (j % 2 == 0)) p[j] = 1'b1;
        else                              n[j] = 1'b1;
      end
      m_lfsr = model_step(m_lfsr);
      e = '{busy: 1'b1, done: 1'b0, cs: 6'(cs), pos: p, neg: n};
      exp_q.push_back(e);
    end
    e = '{busy: 1'b1, done: 1'b1, cs: 6'(cs), pos: 8'h00, neg: 8'h00};
    exp_q.push_back(e);

    start = 1'b1; y = yv; clause_out = cl;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (busy !== e.busy) begin
        errors++; $display("FAIL busy c%0d got %b want %b", c, busy, e.busy);
      end
      checks++;
      if (done !== e.done) begin
        errors++; $display("FAIL done c%0d got %b want %b", c, done, e.done);
      end
      checks++;
      if (class_sum !== e.cs) begin
        errors++; $display("FAIL class_sum c%0d got %0d want %0d", c, class_sum, $signed(e.cs));
      end
      checks++;
      if (pos_fb !== e.pos) begin
        errors++; $display("FAIL pos_fb c%0d got %h want %h", c, pos_fb, e.pos);
      end
      checks++;
      if (neg_fb !== e.neg) begin
        errors++; $display("FAIL neg_fb c%0d got %h want %h", c, neg_fb, e.neg);
      end
      if (c >= 9 && c <= 16) obs_fb[c-9] = {pos_fb, neg_fb};
      start = hold;
      if (hold) begin
        y = ~y;
        clause_out = 8'($urandom);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_done got busy=%b want 0", busy);
    end
    start = 1'b0;
    prev_cs = cs;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; y = 0; clause_out = 0;
    start2 = 0; y2 = 0; clause2 = 0;
    m_lfsr = 16'hACE1; prev_cs = 0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy, done, class_sum, pos_fb, neg_fb} !== 23'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {busy, done, class_sum, pos_fb, neg_fb});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_grant_half();
    run_pass(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) seq_a[i] = obs_fb[i];
  endtask

  task automatic test_sum_no_grant();  run_pass(8'h55, 1'b1, 1'b0); endtask
  task automatic test_all_grant();     run_pass(8'h55, 1'b0, 1'b0); endtask
  task automatic test_hold_start();    run_pass(8'h07, 1'b0, 1'b1); endtask

  task automatic test_back_to_back();
    run_pass(8'hAA, 1'b1, 1'b0);
    run_pass(8'h3C, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midpass();
    start = 1'b1; y = 1'b1; clause_out = 8'hFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, class_sum, pos_fb, neg_fb} !== 23'd0) begin
      errors++; $display("FAIL midpass_reset got %h want 0", {busy, done, class_sum, pos_fb, neg_fb});
    end
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 16'hACE1; prev_cs = 0;
    exp_q.delete();
    @(negedge clk);
    run_pass(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_fb[i] !== seq_a[i]) begin
        errors++; $display("FAIL replay_seq idx%0d got %h want %h", i, obs_fb[i], seq_a[i]);
      end
    end
  endtask

  task automatic test_clamp_t2();
    start2 = 1'b1; y2 = 1'b1; clause2 = 8'h55;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (c == 8) begin
        checks++;
        if (class_sum2 !== 6'sd0) begin
          errors++; $display("FAIL t2_hold got %0d want 0", class_sum2);
        end
      end
      if (c == 9) begin
        checks++;
        if (class_sum2 !== 6'sd2) begin
          errors++; $display("FAIL t2_clamp got %0d want 2", class_sum2);
        end
      end
      if (c == 16 || c == 17) begin
        checks++;
        if (done2 !== (c == 17)) begin
          errors++; $display("FAIL t2_done c%0d got %b want %b", c, done2, (c == 17));
        end
      end
      if (c == 18) begin
        checks++;
        if (busy2 !== 1'b0) begin
          errors++; $display("FAIL t2_idle got %b want 0", busy2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_grant_half();
    test_sum_no_grant();
    test_all_grant();
    test_hold_start();
    test_back_to_back();
    test_reset_midpass();
    test_clamp_t2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/feedback_controller.md
FEEDBACK_CONTROLLER -- requirements
Module: feedback_controller

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N_CLAUSES, 8, number of clauses; even, at least 2.
- THRESH, 4, vote clamp threshold T; at least 1.
- SW, 6, signed class-sum width; must hold -N_CLAUSES/2..+N_CLAUSES/2 and ±2T.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, request to begin one training pass.
- y, in, 1, target class label (1 = belongs to class).
- clause_out, in, N_CLAUSES, clause outputs from the clause stage.
- busy, out, 1, high in every state except IDLE.
- class_sum, out, SW, clamped vote sum (signed).
- pos_fb, out, N_CLAUSES, one-hot positive_feedback pulses (Type I).
- neg_fb, out, N_CLAUSES, one-hot negative_feedback pulses (Type II).
- done, out, 1, one-cycle end-of-pass pulse.

Function
REQ-003 Clause polarity SHALL be fixed: even index = positive vote, odd index = negative vote.
REQ-004 FSM states SHALL be IDLE, SUM, FB and DONE.
REQ-005 IDLE: start=1 SHALL snapshot clause_out and y into internal registers, clear the accumulator and index, and go to SUM.
REQ-006 start SHALL be ignored outside IDLE; the snapshot SHALL NOT change during a pass.
REQ-007 SUM SHALL process one clause per cycle, idx 0..N_CLAUSES-1: accumulator +1 (even idx, clause=1), -1 (odd idx, clause=1), else unchanged.
REQ-008 After the last SUM cycle, the clamped sum (accumulator limited to -T..+T) SHALL be registered into class_sum, idx SHALL clear, and the FSM SHALL go to FB.
REQ-009 FB SHALL visit one clause per cycle, idx 0..N_CLAUSES-1, computing k = T - class_sum if y=1, else k = T + class_sum (range 0..2T).
REQ-010 FB SHALL grant feedback when r*2T < k*256, with r = lfsr[7:0] in the current cycle; k=0 SHALL never grant and k=2T SHALL always grant.
REQ-011 Feedback type on a grant SHALL be:
- y=1: even idx -> pos_fb[idx], odd idx -> neg_fb[idx].
- y=0: even idx -> neg_fb[idx], odd idx -> pos_fb[idx].
REQ-012 pos_fb and neg_fb SHALL be registered outputs, at most one bit set across both, each set for exactly one cycle per grant, and zero outside FB.
REQ-013 The LFSR SHALL be a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances only in FB cycles.
REQ-014 After the last FB cycle the FSM SHALL go to DONE; DONE SHALL pulse done for one cycle and then go to IDLE.
REQ-015 Latency SHALL be: start accepted in cycle 0, SUM in cycles 1..N, FB in cycles N+1..2N, done in cycle 2N+1, start accepted again from cycle 2N+2.
REQ-016 class_sum SHALL hold its value from the end of SUM until the next pass's SUM completes.
REQ-017 start=1 in the DONE cycle SHALL be ignored.

Reset
REQ-018 rst=1 SHALL force, asynchronously and at any point including mid-pass, FSM=IDLE, busy=0, done=0, class_sum=0, pos_fb=0, neg_fb=0, idx=0, accumulator=0, snapshot=0 and lfsr=16'hACE1.
REQ-019 The first start after rst deasserts SHALL be serviced normally.

Verification
REQ-020 N=8, T=4, clause_out=8'h55, y=1 -> class_sum=+4 and k=0, no pos_fb or neg_fb bit set, done in cycle 17.
REQ-021 Same clause_out, y=0 -> k=8, all 8 clauses granted: neg_fb pulses on 0,2,4,6 and pos_fb pulses on 1,3,5,7, in idx order during cycles 9..16.
REQ-022 clause_out=8'hFF, y=1 -> class_sum=0, k=4, grants exactly when lfsr[7:0]<128, matching a bit-exact LFSR model from seed ACE1.
REQ-023 start held high and clause_out toggled through a pass -> a single pass, unchanged snapshot results, busy=1 in cycles 1..16.
REQ-024 rst asserted in cycle 10 (mid-FB) -> all outputs 0 immediately, FSM=IDLE, and a later pass reproduces the post-reset LFSR grant sequence.
REQ-025 N=8, T=2, clause_out=8'h55 -> raw sum +4 clamped so class_sum=+2.
